cdc_2phase_dst_fifo: RTL and testbench

//  Destination half of a two-phase (toggle req/ack) clock domain crossing, generalised to a

---
 rtl/cdc_2phase_pkg.sv | 14 +
 rtl/cdc_sync_srst.sv | 28 ++
 rtl/cdc_2phase_dst_fifo.sv | 130 +++++++++++++
 tb/tb_cdc_2phase_dst_fifo.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/cdc_2phase_pkg.sv
// Shared definitions for the two-phase CDC destination FIFO: counter width,
// the counter type and the level-width helper.
package cdc_2phase_pkg;

  localparam int CDC_CNT_W = 16;

  typedef logic [CDC_CNT_W-1:0] cdc_cnt_t;

  // Bits needed to hold an occupancy value from 0 to depth inclusive.
  function automatic int level_width(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/cdc_sync_srst.sv
// Shift-register synchroniser with synchronous active-high reset.
// The flops carry async_reg/dont_touch so that implementation keeps them
// adjacent and unoptimised.
module cdc_sync_srst
  import cdc_2phase_pkg::*;
#(
  parameter int STAGES = 2
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic d_i,
  output logic q_o
);

  (* async_reg = "true", dont_touch = "true" *) logic [STAGES-1:0] sync_q;

  // Shift the asynchronous input through STAGES flops; reset clears the chain.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], d_i};
    end
  end

  assign q_o = sync_q[STAGES-1];

endmodule

// File: rtl/cdc_2phase_dst_fifo.sv
// Destination half of a two-phase (toggle req/ack) clock domain crossing with
// a FIFO_DEPTH-entry receive buffer. The ack toggles when an item is captured
// into the buffer, so the source can launch its next item while the sink stalls.
// Optional feature macro: CDC_2PHASE_DST_CNT_EN enables the 16-bit transfer counter
// on xfer_cnt_o; without it the port is tied to zero.
module cdc_2phase_dst_fifo
  import cdc_2phase_pkg::*;
#(
  parameter int DATA_WIDTH  = 8,
  parameter int SYNC_STAGES = 2,
  parameter int FIFO_DEPTH  = 2
) (
  input  logic                                clk_i,
  input  logic                                rst_i,
  input  logic                                clear_i,
  output logic [DATA_WIDTH-1:0]               data_o,
  output logic                                valid_o,
  input  logic                                ready_i,
  output logic [level_width(FIFO_DEPTH)-1:0]  level_o,
  input  logic                                async_req_i,
  output logic                                async_ack_o,
  input  logic [DATA_WIDTH-1:0]               async_data_i,
  output logic [CDC_CNT_W-1:0]                xfer_cnt_o
);

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int LVL_W = level_width(FIFO_DEPTH);
  localparam logic [PTR_W-1:0] LAST_PTR  = PTR_W'(FIFO_DEPTH - 1);
  localparam logic [LVL_W-1:0] DEPTH_LVL = LVL_W'(FIFO_DEPTH);

  logic                  req_q;
  logic                  ack_q;
  logic                  ctrl_rst;
  logic                  pending;
  logic                  full;
  logic                  push;
  logic                  pop;
  logic [PTR_W-1:0]      wr_ptr;
  logic [PTR_W-1:0]      rd_ptr;
  logic [PTR_W-1:0]      rd_ptr_nxt;
  logic [LVL_W-1:0]      level_q;
  logic [DATA_WIDTH-1:0] data_q;
  logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];

  // Pointers wrap modulo FIFO_DEPTH, which need not be a power of two.
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == LAST_PTR) ? '0 : p + PTR_W'(1);
  endfunction

  // Soft clear behaves like reset for all state, including the synchroniser.
  assign ctrl_rst = rst_i | clear_i;

  cdc_sync_srst #(
    .STAGES (SYNC_STAGES)
  ) u_req_sync (
    .clk_i (clk_i),
    .rst_i (ctrl_rst),
    .d_i   (async_req_i),
    .q_o   (req_q)
  );

  assign pending    = req_q ^ ack_q;
  assign full       = (level_q == DEPTH_LVL);
  assign valid_o    = (level_q != '0);
  assign pop        = valid_o & ready_i;
  assign push       = pending & (~full | pop);
  assign rd_ptr_nxt = pop ? ptr_inc(rd_ptr) : rd_ptr;

  // Handshake and occupancy control; ack toggles on the capture edge only.
  always_ff @(posedge clk_i) begin
    if (ctrl_rst) begin
      ack_q   <= 1'b0;
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      level_q <= '0;
    end else begin
      if (push) begin
        ack_q  <= ~ack_q;
        wr_ptr <= ptr_inc(wr_ptr);
      end
      rd_ptr <= rd_ptr_nxt;
      if (push && !pop) begin
        level_q <= level_q + LVL_W'(1);
      end else if (!push && pop) begin
        level_q <= level_q - LVL_W'(1);
      end
    end
  end

  // Storage write at the tail; contents need no reset since level gates use.
  always_ff @(posedge clk_i) begin
    if (push && !ctrl_rst) begin
      mem[wr_ptr] <= async_data_i;
    end
  end

  // Registered head: take the incoming item when it lands on the new head slot
  // (buffer empty after this edge's pop), otherwise the entry the head moves to.
  always_ff @(posedge clk_i) begin
    if (ctrl_rst) begin
      data_q <= '0;
    end else if (push && (wr_ptr == rd_ptr_nxt)) begin
      data_q <= async_data_i;
    end else if (pop) begin
      data_q <= mem[rd_ptr_nxt];
    end
  end

  assign data_o      = data_q;
  assign level_o     = level_q;
  assign async_ack_o = ack_q;

`ifdef CDC_2PHASE_DST_CNT_EN
  cdc_cnt_t xfer_cnt_q;

  // Count every captured item; wraps naturally at 16 bits.
  always_ff @(posedge clk_i) begin
    if (ctrl_rst) begin
      xfer_cnt_q <= '0;
    end else if (push) begin
      xfer_cnt_q <= xfer_cnt_q + CDC_CNT_W'(1);
    end
  end

  assign xfer_cnt_o = xfer_cnt_q;
`else
  assign xfer_cnt_o = '0;
`endif

endmodule

// File: tb/tb_cdc_2phase_dst_fifo.sv
// Self-checking bench for cdc_2phase_dst_fifo (DATA_WIDTH=8, SYNC_STAGES=2,
// FIFO_DEPTH=2). Directed scenarios plus a randomized run against an
// in-order queue model of the items the source has launched.
module tb_cdc_2phase_dst_fifo;

  localparam int DW = 8;
  localparam int SS = 2;
  localparam int FD = 2;
  localparam int LW = $clog2(FD + 1);

  logic          clk = 1'b0;
  logic          rst_i;
  logic          clear_i;
  logic [DW-1:0] data_o;
  logic          valid_o;
  logic          ready_i;
  logic [LW-1:0] level_o;
  logic          async_req_i;
  logic          async_ack_o;
  logic [DW-1:0] async_data_i;
  logic [15:0]   xfer_cnt_o;

  int n_cmp = 0;
  int n_err = 0;

  cdc_2phase_dst_fifo #(
    .DATA_WIDTH  (DW),
    .SYNC_STAGES (SS),
    .FIFO_DEPTH  (FD)
  ) dut (
    .clk_i        (clk),
    .rst_i        (rst_i),
    .clear_i      (clear_i),
    .data_o       (data_o),
    .valid_o      (valid_o),
    .ready_i      (ready_i),
    .level_o      (level_o),
    .async_req_i  (async_req_i),
    .async_ack_o  (async_ack_o),
    .async_data_i (async_data_i),
    .xfer_cnt_o   (xfer_cnt_o)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_i = 1'b1; clear_i = 1'b0; ready_i = 1'b0;
    async_req_i = 1'b0; async_data_i = '0;
    repeat (2) tick();
    rst_i = 1'b0;
    tick();
  endtask

  task automatic send(input logic [DW-1:0] d);
    async_data_i = d;
    async_req_i  = ~async_req_i;
  endtask

  task automatic wait_ack(input string nm);
    for (int i = 0; i < 20 && async_ack_o !== async_req_i; i++) tick();
    n_cmp++;
    if (async_ack_o !== async_req_i) begin
      n_err++;
      $display("FAIL %s: ack=%b never reached req=%b within 20 cycles", nm, async_ack_o, async_req_i);
    end
  endtask

  task automatic test_reset();
    rst_i = 1'b1; clear_i = 1'b0; ready_i = 1'b0;
    async_req_i = 1'b0; async_data_i = '0;
    tick();
    n_cmp++;
    if (valid_o !== 1'b0 || level_o !== '0 || async_ack_o !== 1'b0 || xfer_cnt_o !== 16'h0 || data_o !== '0) begin
      n_err++;
      $display("FAIL reset_first_edge: valid=%b level=%0d ack=%b cnt=%0d data=%h, want all 0",
               valid_o, level_o, async_ack_o, xfer_cnt_o, data_o);
    end
    repeat (2) tick();
    rst_i = 1'b0;
    tick();
    n_cmp++;
    if (valid_o !== 1'b0 || level_o !== '0 || async_ack_o !== 1'b0) begin
      n_err++;
      $display("FAIL reset_release: valid=%b level=%0d ack=%b, want 0", valid_o, level_o, async_ack_o);
    end
  endtask

  task automatic test_single();
    do_reset();
    send(8'hA5);
    tick();
    tick();
    n_cmp++;
    if (async_ack_o !== 1'b0 || valid_o !== 1'b0) begin
      n_err++;
      $display("FAIL single_early: ack=%b valid=%b one edge before capture, want 0 0", async_ack_o, valid_o);
    end
    tick();
    n_cmp++;
    if (async_ack_o !== 1'b1 || valid_o !== 1'b1 || data_o !== 8'hA5 || level_o !== LW'(1)) begin
      n_err++;
      $display("FAIL single_capture: ack=%b valid=%b data=%h level=%0d, want 1 1 a5 1",
               async_ack_o, valid_o, data_o, level_o);
    end
    ready_i = 1'b1;
    tick();
    ready_i = 1'b0;
    n_cmp++;
    if (valid_o !== 1'b0 || level_o !== '0) begin
      n_err++;
      $display("FAIL single_pop: valid=%b level=%0d, want 0 0", valid_o, level_o);
    end
  endtask

  task automatic test_backpressure();
    do_reset();
    send(8'h11); wait_ack("bp_ack1");
    send(8'h22); wait_ack("bp_ack2");
    send(8'h33);
    repeat (6) tick();
    n_cmp++;
    if (level_o !== LW'(2) || async_ack_o !== 1'b0 || data_o !== 8'h11) begin
      n_err++;
      $display("FAIL bp_full_hold: level=%0d ack=%b data=%h, want 2 0 11", level_o, async_ack_o, data_o);
    end
    ready_i = 1'b1;
    tick();
    n_cmp++;
    if (level_o !== LW'(2) || async_ack_o !== 1'b1 || data_o !== 8'h22) begin
      n_err++;
      $display("FAIL full_push_pop: level=%0d ack=%b data=%h, want 2 1 22", level_o, async_ack_o, data_o);
    end
    tick();
    n_cmp++;
    if (level_o !== LW'(1) || valid_o !== 1'b1 || data_o !== 8'h33) begin
      n_err++;
      $display("FAIL bp_order3: level=%0d valid=%b data=%h, want 1 1 33", level_o, valid_o, data_o);
    end
    tick();
    ready_i = 1'b0;
    n_cmp++;
    if (level_o !== '0 || valid_o !== 1'b0) begin
      n_err++;
      $display("FAIL bp_drain: level=%0d valid=%b, want 0 0 (no duplicate)", level_o, valid_o);
    end
  endtask

  task automatic test_clear();
    do_reset();
    send(8'h77); wait_ack("clr_ack1");
    send(8'h88);
    tick();
    clear_i     = 1'b1;
    async_req_i = 1'b0;
    tick();
    clear_i = 1'b0;
    n_cmp++;
    if (valid_o !== 1'b0 || level_o !== '0 || async_ack_o !== 1'b0) begin
      n_err++;
      $display("FAIL clear_state: valid=%b level=%0d ack=%b, want 0 0 0", valid_o, level_o, async_ack_o);
    end
    repeat (5) tick();
    n_cmp++;
    if (valid_o !== 1'b0 || async_ack_o !== 1'b0) begin
      n_err++;
      $display("FAIL clear_ghost: valid=%b ack=%b after clear, want 0 0", valid_o, async_ack_o);
    end
    send(8'h5A); wait_ack("clr_ack2");
    n_cmp++;
    if (valid_o !== 1'b1 || data_o !== 8'h5A || level_o !== LW'(1)) begin
      n_err++;
      $display("FAIL clear_next_item: valid=%b data=%h level=%0d, want 1 5a 1", valid_o, data_o, level_o);
    end
  endtask

  task automatic test_mid_reset();
    do_reset();
    send(8'hC3); wait_ack("mr_ack1");
    send(8'h3C);
    tick();
    rst_i       = 1'b1;
    async_req_i = 1'b0;
    tick();
    rst_i = 1'b0;
    repeat (4) tick();
    n_cmp++;
    if (valid_o !== 1'b0 || level_o !== '0 || async_ack_o !== 1'b0) begin
      n_err++;
      $display("FAIL mid_reset: valid=%b level=%0d ack=%b, want 0 0 0", valid_o, level_o, async_ack_o);
    end
  endtask

  task automatic test_random();
    logic [DW-1:0] sent[$];
    logic [DW-1:0] d;
    int            nsent;
    int            exp_lvl;
    logic [15:0]   exp_cnt;
    do_reset();
    nsent = 0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      // Items launched but not yet consumed, minus the one still in flight.
      exp_lvl = sent.size() - ((async_req_i !== async_ack_o) ? 1 : 0);
      n_cmp++;
      if (int'(level_o) !== exp_lvl) begin
        n_err++;
        $display("FAIL rand_level cyc %0d: level=%0d, want %0d", cyc, level_o, exp_lvl);
      end
      if (async_req_i === async_ack_o && $urandom_range(0, 3) != 0) begin
        d = DW'($urandom);
        send(d);
        sent.push_back(d);
        nsent++;
      end
      if (cyc < 1000)      ready_i = ($urandom_range(0, 4) == 0);
      else if (cyc < 2000) ready_i = ($urandom_range(0, 1) == 0);
      else                 ready_i = ($urandom_range(0, 4) != 0);
      if (valid_o === 1'b1 && ready_i) begin
        n_cmp++;
        if (sent.size() == 0 || data_o !== sent[0]) begin
          n_err++;
          $display("FAIL rand_data cyc %0d: data=%h, want %h", cyc, data_o,
                   (sent.size() != 0) ? sent[0] : 8'h00);
        end
        if (sent.size() != 0) void'(sent.pop_front());
      end
      tick();
    end
    ready_i = 1'b1;
    for (int i = 0; i < 50 && sent.size() != 0; i++) begin
      if (valid_o === 1'b1) begin
        n_cmp++;
        if (data_o !== sent[0]) begin
          n_err++;
          $display("FAIL rand_drain: data=%h, want %h", data_o, sent[0]);
        end
        void'(sent.pop_front());
      end
      tick();
    end
    ready_i = 1'b0;
    n_cmp++;
    if (sent.size() != 0 || valid_o !== 1'b0) begin
      n_err++;
      $display("FAIL rand_empty: %0d items undelivered, valid=%b, want 0 0", sent.size(), valid_o);
    end
`ifdef CDC_2PHASE_DST_CNT_EN
    exp_cnt = 16'(nsent);
`else
    exp_cnt = 16'h0;
`endif
    n_cmp++;
    if (xfer_cnt_o !== exp_cnt) begin
      n_err++;
      $display("FAIL xfer_cnt: cnt=%0d, want %0d", xfer_cnt_o, exp_cnt);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_backpressure();
    test_clear();
    test_mid_reset();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
